issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter_pkg.sv | 27 ++
 rtl/issue_arbiter_rr_arbiter.sv | 43 ++++
 rtl/issue_arbiter.sv | 80 ++++++++
 tb/tb_issue_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_arbiter_pkg.sv
// Shared types and fixed writeback latencies for the issue stage.
// Thread index width is fixed here; NUM_THREADS must not exceed 2**THREAD_IDX_W.
package issue_arbiter_pkg;

    typedef enum logic [1:0] {
        PIPE_INT_ARITH   = 2'd0,
        PIPE_MEM         = 2'd1,
        PIPE_FLOAT_ARITH = 2'd2
    } pipeline_sel_t;

    localparam int THREAD_IDX_W = 2;
    typedef logic [THREAD_IDX_W-1:0] local_thread_idx_t;

    localparam int LAT_INT_ARITH   = 3;
    localparam int LAT_MEM         = 4;
    localparam int LAT_FLOAT_ARITH = 7;

    // Unused encodings fall back to the integer latency.
    function automatic int pipe_latency(input pipeline_sel_t pipe);
        case (pipe)
            PIPE_MEM:         return LAT_MEM;
            PIPE_FLOAT_ARITH: return LAT_FLOAT_ARITH;
            default:          return LAT_INT_ARITH;
        endcase
    endfunction

endpackage

// File: rtl/issue_arbiter_rr_arbiter.sv
// Round-robin priority picker: one-hot grant, search starts one past the last grant.
// The pointer only moves when the caller signals that the grant was taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Reset pointer to the last thread so thread 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= IDX_W'(NUM_REQ - 1);
        else if (update)
            last_grant <= grant_idx;
    end

endmodule

// File: rtl/issue_arbiter.sv
// Per-cycle issue selection across hardware threads with a single-port
// writeback reservation window to avoid writeback collisions.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int WB_SLOTS    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic          [NUM_THREADS-1:0] thread_en,
    input  logic          [NUM_THREADS-1:0] ts_ready,
    input  pipeline_sel_t [NUM_THREADS-1:0] ts_pipeline,
    input  logic          [NUM_THREADS-1:0] ts_has_dest,
    output logic          [NUM_THREADS-1:0] will_issue,
    output logic                            issue_valid,
    output local_thread_idx_t               issue_thread_idx,
    output pipeline_sel_t                   issue_pipeline
);

    localparam int SLOT_W = $clog2(WB_SLOTS);

    logic [WB_SLOTS-1:0]    wb_reserved;
    logic [WB_SLOTS-1:0]    wb_reserved_next;
    logic [NUM_THREADS-1:0] candidate;
    logic [NUM_THREADS-1:0] grant;
    logic                   grant_has_dest;
    int                     grant_lat;

    // A thread with a destination may only issue if its writeback slot is free.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            candidate[t] = thread_en[t] & ts_ready[t] &
                           ~(ts_has_dest[t] & wb_reserved[SLOT_W'(pipe_latency(ts_pipeline[t]))]);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_THREADS)
    ) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (candidate),
        .update (issue_valid),
        .grant  (grant)
    );

    always_comb begin
        will_issue       = reset ? '0 : grant;
        issue_valid      = |will_issue;
        issue_thread_idx = '0;
        issue_pipeline   = PIPE_INT_ARITH;
        grant_has_dest   = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (will_issue[t]) begin
                issue_thread_idx = local_thread_idx_t'(t);
                issue_pipeline   = ts_pipeline[t];
                grant_has_dest   = ts_has_dest[t];
            end
        end
        grant_lat = pipe_latency(issue_pipeline);
    end

    // Window shifts toward "now"; a new claim lands at LAT-1 since one cycle elapses.
    always_comb begin
        wb_reserved_next = '0;
        for (int k = 0; k < WB_SLOTS - 1; k++) begin
            wb_reserved_next[k] = wb_reserved[k+1] |
                                  (issue_valid & grant_has_dest & (grant_lat == k + 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wb_reserved <= '0;
        else
            wb_reserved <= wb_reserved_next;
    end

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed and model-checked random stimulus for issue_arbiter.
module tb_issue_arbiter;
    import issue_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0]            thread_en;
    logic [3:0]            ts_ready;
    pipeline_sel_t [3:0]   ts_pipeline;
    logic [3:0]            ts_has_dest;
    logic [3:0]            will_issue;
    logic                  issue_valid;
    local_thread_idx_t     issue_thread_idx;
    pipeline_sel_t         issue_pipeline;

    int n_checks = 0;
    int n_pass   = 0;

    issue_arbiter #(
        .NUM_THREADS (4),
        .WB_SLOTS    (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .thread_en        (thread_en),
        .ts_ready         (ts_ready),
        .ts_pipeline      (ts_pipeline),
        .ts_has_dest      (ts_has_dest),
        .will_issue       (will_issue),
        .issue_valid      (issue_valid),
        .issue_thread_idx (issue_thread_idx),
        .issue_pipeline   (issue_pipeline)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] rdy, input logic [3:0] dest);
        thread_en   = en;
        ts_ready    = rdy;
        ts_has_dest = dest;
        for (int i = 0; i < 4; i++) ts_pipeline[i] = PIPE_INT_ARITH;
    endtask

    // Check the combinational grant, then advance one clock.
    task automatic expect_grant(input string tag, input logic [3:0] exp);
        #1;
        check(tag, 32'(will_issue), 32'(exp));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int lat_of(input pipeline_sel_t p);
        case (p)
            PIPE_MEM:         return 4;
            PIPE_FLOAT_ARITH: return 7;
            default:          return 3;
        endcase
    endfunction

    // Reference model state for the random phase
    logic [7:0]  m_wb;
    int          m_last;
    logic [63:0] claim;
    logic [3:0]  exp_g;
    int          exp_t;
    logic        cand;

    initial begin
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_will_issue", 32'(will_issue), 32'h0);
        check("rst_valid", 32'(issue_valid), 32'h0);
        check("rst_idx", 32'(issue_thread_idx), 32'h0);
        reset = 1'b0;

        // Full round robin from reset
        expect_grant("rr_all_0", 4'b0001);
        expect_grant("rr_all_1", 4'b0010);
        expect_grant("rr_all_2", 4'b0100);
        expect_grant("rr_all_3", 4'b1000);
        expect_grant("rr_all_4", 4'b0001);

        // Sparse ready, then disabled thread
        do_reset();
        drive(4'b1111, 4'b0101, 4'b0000);
        expect_grant("rr_0101_0", 4'b0001);
        expect_grant("rr_0101_1", 4'b0100);
        expect_grant("rr_0101_2", 4'b0001);
        expect_grant("rr_0101_3", 4'b0100);
        thread_en = 4'b1011;
        expect_grant("en2_off_0", 4'b0001);
        expect_grant("en2_off_1", 4'b0001);
        drive(4'b1111, 4'b0000, 4'b0000);
        expect_grant("no_ready", 4'b0000);

        // Float writeback blocks an int writeback four cycles later
        do_reset();
        drive(4'b1111, 4'b0001, 4'b0001);
        ts_pipeline[0] = PIPE_FLOAT_ARITH;
        #1;
        check("float_pipe", 32'(issue_pipeline), 32'(PIPE_FLOAT_ARITH));
        expect_grant("float_N", 4'b0001);
        drive(4'b1111, 4'b0000, 4'b0000);
        repeat (3) expect_grant("float_idle", 4'b0000);
        drive(4'b1111, 4'b0010, 4'b0010);
        expect_grant("int_dest_N4", 4'b0000);
        #1;
        check("int_dest_N5_idx", 32'(issue_thread_idx), 32'd1);
        expect_grant("int_dest_N5", 4'b0010);

        // No destination never conflicts
        do_reset();
        drive(4'b1111, 4'b0001, 4'b0001);
        ts_pipeline[0] = PIPE_FLOAT_ARITH;
        expect_grant("float2_N", 4'b0001);
        drive(4'b1111, 4'b0000, 4'b0000);
        repeat (3) expect_grant("float2_idle", 4'b0000);
        drive(4'b1111, 4'b0010, 4'b0000);
        expect_grant("int_nodest_N4", 4'b0010);

        // Memory latency conflict boundary
        do_reset();
        drive(4'b1111, 4'b0001, 4'b0001);
        ts_pipeline[0] = PIPE_FLOAT_ARITH;
        expect_grant("float3_N", 4'b0001);
        drive(4'b1111, 4'b0000, 4'b0000);
        repeat (2) expect_grant("float3_idle", 4'b0000);
        drive(4'b1111, 4'b0010, 4'b0010);
        ts_pipeline[1] = PIPE_MEM;
        expect_grant("mem_dest_N3", 4'b0000);
        #1;
        check("mem_dest_N4_pipe", 32'(issue_pipeline), 32'(PIPE_MEM));
        expect_grant("mem_dest_N4", 4'b0010);

        // Reset mid-stream with reservations outstanding
        do_reset();
        drive(4'b1111, 4'b0001, 4'b0001);
        ts_pipeline[0] = PIPE_FLOAT_ARITH;
        expect_grant("pre_rst_N", 4'b0001);
        drive(4'b1111, 4'b1111, 4'b0001);
        ts_pipeline[0] = PIPE_MEM;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_will_issue", 32'(will_issue), 32'h0);
        check("mid_rst_valid", 32'(issue_valid), 32'h0);
        check("mid_rst_pipe", 32'(issue_pipeline), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_grant("post_rst_first", 4'b0001);
        expect_grant("post_rst_second", 4'b0010);

        // Random traffic against a reference model
        do_reset();
        m_wb   = '0;
        m_last = 3;
        claim  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            thread_en   = 4'($urandom_range(0, 15)) | 4'b1001;
            ts_ready    = 4'($urandom_range(0, 15));
            ts_has_dest = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                ts_pipeline[i] = pipeline_sel_t'($urandom_range(0, 2));
            #1;
            exp_g = '0;
            exp_t = -1;
            for (int i = 1; i <= 4; i++) begin
                int t;
                t = (m_last + i) % 4;
                cand = thread_en[t] && ts_ready[t] &&
                       !(ts_has_dest[t] && m_wb[lat_of(ts_pipeline[t])]);
                if (exp_t < 0 && cand) begin
                    exp_t    = t;
                    exp_g[t] = 1'b1;
                end
            end
            check("rand_grant", 32'(will_issue), 32'(exp_g));
            check("rand_onehot", 32'($countones(will_issue) <= 1), 32'd1);
            m_wb = m_wb >> 1;
            if (exp_t >= 0) begin
                m_last = exp_t;
                if (ts_has_dest[exp_t])
                    m_wb[lat_of(ts_pipeline[exp_t]) - 1] = 1'b1;
            end
            for (int t = 0; t < 4; t++) begin
                if (will_issue[t] && ts_has_dest[t]) begin
                    int s;
                    s = (cyc + lat_of(ts_pipeline[t])) % 64;
                    check("rand_wb_once", 32'(claim[s[5:0]]), 32'd0);
                    claim[s[5:0]] = 1'b1;
                end
            end
            claim[cyc % 64] = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
